pingpong_rd_sched: RTL and testbench

//  Read-side scheduler for the two-bank ping-pong async FIFO pair, in the read-clock domain.

---
 rtl/pingpong_rd_sched_pkg.sv | 21 ++
 rtl/pingpong_rd_sched_rr_arbiter.sv | 42 ++++
 rtl/pingpong_rd_sched.sv | 146 ++++++++++++++
 tb/tb_pingpong_rd_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_rd_sched_pkg.sv
// rtl/pingpong_rd_sched_pkg.sv - FSM encoding and sizing helpers shared by the read scheduler
package pingpong_rd_sched_pkg;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_ARB  = 5'b00010;
  localparam logic [4:0] S_READ = 5'b00100;
  localparam logic [4:0] S_LAST = 5'b01000;
  localparam logic [4:0] S_DONE = 5'b10000;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  function automatic int burst_cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic bit num_req_ok(input int n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

endpackage

// File: rtl/pingpong_rd_sched_rr_arbiter.sv
// rtl/pingpong_rd_sched_rr_arbiter.sv - round-robin arbiter; search starts at the slot after the last winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] win
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    win     = '0;
    w_idx   = r_ptr;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        win[w_cand] = 1'b1;
        w_idx       = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
    end
  end

endmodule

// File: rtl/pingpong_rd_sched.sv
// rtl/pingpong_rd_sched.sv - ping-pong bank read scheduler with round-robin consumer bursts
// Optional PP_SCHED_WORDCNT_EN adds the word_cnt / word_cnt_clr delivered-word counter.
module pingpong_rd_sched
  import pingpong_rd_sched_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 64
) (
  input  logic                 rd_clk,
  input  logic                 rst_n,
  input  logic [1:0]           bank_rdy,
  input  logic [1:0]           bank_empty,
  input  logic [DATA_SIZE-1:0] bank_dout0,
  input  logic [DATA_SIZE-1:0] bank_dout1,
  input  logic [NUM_REQ-1:0]   req,
`ifdef PP_SCHED_WORDCNT_EN
  input  logic                 word_cnt_clr,
  output logic [31:0]          word_cnt,
`endif
  output logic [1:0]           rd_en,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 dout_vld,
  output logic                 dout_last,
  output logic                 busy
);

  localparam int               CNT_W   = burst_cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] C_BURST = CNT_W'(BURST_LEN);

  if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
    $error("pingpong_rd_sched: NUM_REQ must be in 2..8");
  end

  logic [4:0]           r_state;
  logic [1:0]           r_armed;
  logic                 r_cur_bank;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_drained;
  logic                 r_rd_d1;
  logic [DATA_SIZE-1:0] r_dout;
  logic                 r_dout_vld;
  logic                 r_dout_last;

  logic [NUM_REQ-1:0]   w_win;
  logic                 w_sel_empty;
  logic                 w_win_req;
  logic                 w_rd;
  logic [1:0]           w_arm_clr;

  assign w_sel_empty = bank_empty[r_cur_bank];
  assign w_win_req   = |(req & r_gnt);
  assign w_rd        = (r_state == S_READ) && w_win_req && !w_sel_empty && (r_cnt < C_BURST);
  assign w_arm_clr   = (r_state == S_DONE && r_drained) ? (r_cur_bank ? 2'b10 : 2'b01) : 2'b00;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (rd_clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (r_state == S_ARB),
    .win     (w_win)
  );

  // A burst ends on the cycle after its final strobe, once cnt or the empty flag shows it.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_armed    <= 2'b00;
      r_cur_bank <= 1'b0;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_drained  <= 1'b0;
    end else begin
      r_armed <= (r_armed & ~w_arm_clr) | bank_rdy;
      if (w_rd) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: if (r_armed[r_cur_bank] && |req) r_state <= S_ARB;
        S_ARB: begin
          r_gnt     <= w_win;
          r_cnt     <= '0;
          r_drained <= 1'b0;
          r_state   <= (|w_win) ? S_READ : S_IDLE;
        end
        S_READ: begin
          if (w_sel_empty) r_drained <= 1'b1;
          if (r_cnt == C_BURST || (w_sel_empty && r_cnt != '0)) begin
            r_state <= S_LAST;
          end else if (w_sel_empty) begin
            r_gnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_LAST: begin
          r_gnt   <= '0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (r_drained) r_cur_bank <= ~r_cur_bank;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bank data arrives one cycle after the strobe and is captured into the output register.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d1     <= 1'b0;
      r_dout      <= '0;
      r_dout_vld  <= 1'b0;
      r_dout_last <= 1'b0;
    end else begin
      r_rd_d1     <= w_rd;
      r_dout_vld  <= r_rd_d1;
      r_dout_last <= r_rd_d1 && (r_cnt == C_BURST || w_sel_empty);
      if (r_rd_d1) r_dout <= r_cur_bank ? bank_dout1 : bank_dout0;
    end
  end

`ifdef PP_SCHED_WORDCNT_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (word_cnt_clr) begin
      r_word_cnt <= '0;
    end else if (r_dout_vld) begin
      r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

  assign rd_en     = {w_rd & r_cur_bank, w_rd & ~r_cur_bank};
  assign gnt       = r_gnt;
  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign dout_last = r_dout_last;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pingpong_rd_sched.sv
// tb/tb_pingpong_rd_sched.sv - randomized scoreboard bench for pingpong_rd_sched (PP_SCHED_WORDCNT_EN optional)
module tb_pingpong_rd_sched;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int BL = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    bank_rdy;
  logic [1:0]    bank_empty;
  logic [DW-1:0] bank_dout0;
  logic [DW-1:0] bank_dout1;
  logic [NR-1:0] req;
  logic [1:0]    rd_en;
  logic [NR-1:0] gnt;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_last;
  logic          busy;
`ifdef PP_SCHED_WORDCNT_EN
  logic          word_cnt_clr;
  logic [31:0]   word_cnt;
  longint        wc_model;
  int            wc_err;
`endif

  pingpong_rd_sched #(.DATA_SIZE(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .rd_clk       (clk),
    .rst_n        (rst_n),
    .bank_rdy     (bank_rdy),
    .bank_empty   (bank_empty),
    .bank_dout0   (bank_dout0),
    .bank_dout1   (bank_dout1),
    .req          (req),
`ifdef PP_SCHED_WORDCNT_EN
    .word_cnt_clr (word_cnt_clr),
    .word_cnt     (word_cnt),
`endif
    .rd_en        (rd_en),
    .gnt          (gnt),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .dout_last    (dout_last),
    .busy         (busy)
  );

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] fifo0[$];
  logic [DW-1:0] fifo1[$];
  logic [DW-1:0] exp_words[$];
  logic [DW-1:0] obs_words[$];
  int            exp_len[$];
  int            obs_len[$];
  logic [NR-1:0] exp_gnt[$];
  logic [NR-1:0] obs_gnt[$];
  int            cur_len, proto_err, rd0_cnt, rd1_cnt, stall_err, rr_ptr;
  bit            stall_on;
  logic [NR-1:0] prev_gnt;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (rd_en == 2'b11) proto_err++;
    if (rd_en[0]) rd0_cnt++;
    if (rd_en[1]) rd1_cnt++;
    if (dout_last && !dout_vld) proto_err++;
    if (gnt != '0 && !$onehot(gnt)) proto_err++;
    if (stall_on && (rd_en != 2'b00 || gnt != 4'b0001)) stall_err++;
    if (dout_vld) begin
      obs_words.push_back(dout);
      cur_len++;
      if (dout_last) begin
        obs_len.push_back(cur_len);
        cur_len = 0;
      end
    end
    if (gnt != '0 && prev_gnt == '0) obs_gnt.push_back(gnt);
    prev_gnt = gnt;
`ifdef PP_SCHED_WORDCNT_EN
    if (!rst_n) wc_model = 0;
    if (word_cnt !== wc_model[31:0]) wc_err++;
    if (rst_n) wc_model = word_cnt_clr ? 0 : ((wc_model + longint'(dout_vld)) & 64'hFFFF_FFFF);
`endif
  endtask

  task automatic upd_empty();
    bank_empty = {(fifo1.size() == 0), (fifo0.size() == 0)};
  endtask

  task automatic step();
    logic [1:0] rs;
    @(negedge clk);
    rs = rd_en;
    observe();
    @(posedge clk);
    #1;
    if (rs[0]) begin
      if (fifo0.size() > 0) bank_dout0 = fifo0.pop_front(); else proto_err++;
    end
    if (rs[1]) begin
      if (fifo1.size() > 0) bank_dout1 = fifo1.pop_front(); else proto_err++;
    end
    bank_rdy = 2'b00;
    upd_empty();
  endtask

  task automatic clear_obs();
    obs_words.delete(); exp_words.delete();
    obs_len.delete();   exp_len.delete();
    obs_gnt.delete();   exp_gnt.delete();
    cur_len = 0; proto_err = 0; rd0_cnt = 0; rd1_cnt = 0; stall_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; bank_rdy = 2'b00;
    fifo0.delete(); fifo1.delete(); upd_empty();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    clear_obs();
    rr_ptr = 0;
  endtask

  task automatic fill(input int b, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      if (b == 0) fifo0.push_back(w); else fifo1.push_back(w);
    end
    upd_empty();
  endtask

  // Expected stream for draining bank b as it stands now, with round-robin grants under pattern pat.
  task automatic add_exp(input int b, input logic [NR-1:0] pat);
    int n, l, idx;
    bit found;
    n = (b == 0) ? fifo0.size() : fifo1.size();
    for (int i = 0; i < n; i++) exp_words.push_back((b == 0) ? fifo0[i] : fifo1[i]);
    while (n > 0) begin
      l = (n > BL) ? BL : n;
      exp_len.push_back(l);
      n -= l;
      found = 1'b0; idx = 0;
      for (int k = 0; k < NR; k++) begin
        if (!found && pat[(rr_ptr + k) % NR]) begin
          found = 1'b1;
          idx = (rr_ptr + k) % NR;
        end
      end
      exp_gnt.push_back(NR'(1) << idx);
      rr_ptr = (idx + 1) % NR;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (obs_words.size() >= exp_words.size() && !busy) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_until_words(input string tag, input int n);
    int i;
    i = 0;
    while (obs_words.size() < n && i < 1000) begin
      step();
      i++;
    end
    if (obs_words.size() < n) check({tag, "_timeout"}, obs_words.size(), n);
  endtask

  task automatic check_stream(input string tag);
    int mism;
    check({tag, "_nwords"}, obs_words.size(), exp_words.size());
    mism = 0;
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++)
      if (obs_words[i] !== exp_words[i]) mism++;
    check({tag, "_data"}, mism, 0);
    check({tag, "_nburst"}, obs_len.size(), exp_len.size());
    mism = 0;
    for (int i = 0; i < obs_len.size() && i < exp_len.size(); i++)
      if (obs_len[i] != exp_len[i]) mism++;
    check({tag, "_lens"}, mism, 0);
    mism = 0;
    for (int i = 0; i < obs_gnt.size() && i < exp_gnt.size(); i++)
      if (obs_gnt[i] !== exp_gnt[i]) mism++;
    check({tag, "_gnt_seq"}, mism, 0);
    check({tag, "_proto"}, proto_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2_lens[4];
    logic [NR-1:0] t3_gnt[4];
    logic [NR-1:0] pat;
    int snap;
    t2_lens = '{64, 64, 64, 8};
    t3_gnt  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rst_n = 1'b1; bank_rdy = 2'b00; bank_empty = 2'b11; bank_dout0 = '0; bank_dout1 = '0;
    req = '0; stall_on = 1'b0; prev_gnt = '0; rr_ptr = 0;
`ifdef PP_SCHED_WORDCNT_EN
    word_cnt_clr = 1'b0; wc_model = 0; wc_err = 0;
`endif
    clear_obs();
    #2 rst_n = 1'b0;

    // T1 reset with random requests
    for (int i = 0; i < 4; i++) begin
      req = NR'($urandom);
      @(negedge clk);
      check("t1_gnt", gnt, 0);
      check("t1_rd_en", rd_en, 0);
      check("t1_dout_vld", dout_vld, 0);
      check("t1_busy", busy, 0);
`ifdef PP_SCHED_WORDCNT_EN
      check("t1_word_cnt", word_cnt, 0);
`endif
    end

    // T2 single consumer, 200 words
    do_reset();
    req = 4'b0001;
    fill(0, 200); add_exp(0, req);
    bank_rdy = 2'b01; step();
    drain("t2", 3000);
    check_stream("t2");
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_len%0d", i), (i < obs_len.size()) ? obs_len[i] : -1, t2_lens[i]);
    clear_obs();
    fill(0, 10);
    bank_rdy = 2'b01; step();
    snap = rd0_cnt;
    repeat (100) step();
    check("t2_bank0_not_reread", rd0_cnt - snap, 0);
    check("t2_idle_waiting_bank1", busy, 0);
    fill(1, 20); add_exp(1, req); add_exp(0, req);
    bank_rdy = 2'b10; step();
    drain("t2b", 3000);
    check_stream("t2b");

    // T3 round-robin over 4'b1011
    do_reset();
    req = 4'b1011;
    fill(0, 256); add_exp(0, req);
    bank_rdy = 2'b01; step();
    drain("t3", 3000);
    check_stream("t3");
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_gnt%0d", i), (i < obs_gnt.size()) ? obs_gnt[i] : 0, t3_gnt[i]);

    // T4 stall mid-burst
    do_reset();
    req = 4'b0001;
    fill(0, 64); add_exp(0, req);
    bank_rdy = 2'b01; step();
    run_until_words("t4", 20);
    req = 4'b0000; stall_on = 1'b1;
    repeat (5) step();
    stall_on = 1'b0; req = 4'b0001;
    drain("t4", 2000);
    check("t4_stall", stall_err, 0);
    check_stream("t4");

    // T5 bank 1 ready first must wait for bank 0
    do_reset();
    req = 4'b0001;
    fill(1, 40);
    bank_rdy = 2'b10; step();
    repeat (30) step();
    check("t5_no_rd1_early", rd1_cnt, 0);
    check("t5_idle", busy, 0);
    fill(0, 30); add_exp(0, req); add_exp(1, req);
    bank_rdy = 2'b01; step();
    drain("t5", 2000);
    check_stream("t5");
    check("t5_rd1_total", rd1_cnt, 40);

    // T6 reset mid-burst, then restart from bank 0
    do_reset();
    req = 4'b0001;
    fill(0, 64);
    bank_rdy = 2'b01; step();
    run_until_words("t6", 30);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_gnt", gnt, 0);
    check("t6_rd_en", rd_en, 0);
    check("t6_dout_vld", dout_vld, 0);
    check("t6_dout_last", dout_last, 0);
    check("t6_busy", busy, 0);
`ifdef PP_SCHED_WORDCNT_EN
    check("t6_word_cnt_rst", word_cnt, 0);
`endif
    repeat (2) step();
    rst_n = 1'b1;
    clear_obs(); rr_ptr = 0;
    fill(1, 20); add_exp(0, req); add_exp(1, req);
    bank_rdy = 2'b11; step();
`ifdef PP_SCHED_WORDCNT_EN
    run_until_words("t6_wc", 10);
    word_cnt_clr = 1'b1;
    step();
    word_cnt_clr = 1'b0;
    check("t6_word_cnt_clr", word_cnt, 0);
`endif
    drain("t6", 2000);
    check_stream("t6");

    // T7 random fills and request patterns across both banks
    for (int it = 0; it < 3; it++) begin
      do_reset();
      pat = NR'($urandom_range(1, 15));
      req = pat;
      fill(0, $urandom_range(1, 150)); fill(1, $urandom_range(1, 150));
      add_exp(0, pat); add_exp(1, pat);
      bank_rdy = 2'b11; step();
      drain($sformatf("t7_%0d", it), 3000);
      check_stream($sformatf("t7_%0d", it));
    end

`ifdef PP_SCHED_WORDCNT_EN
    check("word_cnt_track", wc_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
